raw_issue_queue: RTL and testbench

//  In-order 4-wide issue queue feeding the RAW memory check. Buffers decoded instructions (des/src1/src2 tags + opcode)
//  and presents the oldest 4 to the RAW checker. Combines the checker's hazard flags with an intra-group RAW check,

---
 rtl/raw_issue_queue_if.sv | 50 +++++
 rtl/raw_issue_queue.sv | 168 ++++++++++++++++
 tb/tb_raw_issue_queue.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/raw_issue_queue_if.sv
// Bundle of the decode-side, checker-side and issue-side signals of raw_issue_queue.
// Lanes are packed with lane k at [k*W +: W], and lane 0 is the oldest lane.
// The master modport drives decode, hazard, stall and flush. The slave modport (the queue) drives everything else.
interface raw_issue_queue_if #(
    parameter int DES_W = 4,
    parameter int SRC_W = 4,
    parameter int OP_W  = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    // control from the pipeline
    logic                 flush;
    logic                 iss_stall;
    // decode -> queue
    logic [3:0]           dec_vld;
    logic [4*DES_W-1:0]   dec_des;
    logic [4*SRC_W-1:0]   dec_src1;
    logic [4*SRC_W-1:0]   dec_src2;
    logic [4*OP_W-1:0]    dec_op;
    logic                 dec_rdy;
    // queue <-> RAW checker
    logic [3:0]           chk_vld;
    logic [4*DES_W-1:0]   chk_des;
    logic [4*SRC_W-1:0]   chk_src1;
    logic [4*SRC_W-1:0]   chk_src2;
    logic [3:0]           chk_hz;
    logic [3:0]           fin_vld;
    // queue -> functional units
    logic [3:0]           iss_vld;
    logic [4*DES_W-1:0]   iss_des;
    logic [4*SRC_W-1:0]   iss_src1;
    logic [4*SRC_W-1:0]   iss_src2;
    logic [4*OP_W-1:0]    iss_op;
    // status
    logic [CW-1:0]        count;
    logic [15:0]          stall_cnt;

    modport master (
        output flush, iss_stall, dec_vld, dec_des, dec_src1, dec_src2, dec_op, chk_hz,
        input  dec_rdy, chk_vld, chk_des, chk_src1, chk_src2, fin_vld,
               iss_vld, iss_des, iss_src1, iss_src2, iss_op, count, stall_cnt
    );

    modport slave (
        input  flush, iss_stall, dec_vld, dec_des, dec_src1, dec_src2, dec_op, chk_hz,
        output dec_rdy, chk_vld, chk_des, chk_src1, chk_src2, fin_vld,
               iss_vld, iss_des, iss_src1, iss_src2, iss_op, count, stall_cnt
    );
endinterface

// File: rtl/raw_issue_queue.sv
// In-order 4-wide issue queue. It issues the longest prefix of the oldest four entries that is free of RAW hazards.
// Latency: an entry enqueued in cycle t is checkable in t+1. If it issues in t+1, iss_vld shows it in t+2.
// Backpressure: dec_rdy needs 4 free slots, and no credit is given for a same-cycle dequeue. iss_stall forces zero issue.
// Ports: clk, rst (synchronous, active-low). All other signals are in the bus interface (slave modport):
//   dec_* enqueue, chk_* head window to the checker, chk_hz hazard flags, fin_vld per-lane issue strobe,
//   iss_* registered issued entries, count occupancy, stall_cnt saturating hazard-stall cycle count.
module raw_issue_queue #(
    parameter int DES_W = 4,
    parameter int SRC_W = 4,
    parameter int OP_W  = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    raw_issue_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (DES_W > SRC_W) ? DES_W : SRC_W;

    logic [DES_W-1:0]   mem_des  [DEPTH];
    logic [SRC_W-1:0]   mem_src1 [DEPTH];
    logic [SRC_W-1:0]   mem_src2 [DEPTH];
    logic [OP_W-1:0]    mem_op   [DEPTH];

    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [CW-1:0]      count;
    logic [15:0]        stall_cnt;
    logic [3:0]         iss_vld;
    logic [4*DES_W-1:0] iss_des;
    logic [4*SRC_W-1:0] iss_src1;
    logic [4*SRC_W-1:0] iss_src2;
    logic [4*OP_W-1:0]  iss_op;

    logic               dec_rdy;
    logic               enq;
    logic [2:0]         enq_cnt;
    logic [1:0]         enq_off [4];
    logic [DES_W-1:0]   win_des  [4];
    logic [SRC_W-1:0]   win_src1 [4];
    logic [SRC_W-1:0]   win_src2 [4];
    logic [OP_W-1:0]    win_op   [4];
    logic [3:0]         win_vld;
    logic [3:0]         raw_hit;
    logic [3:0]         fin_vld;
    logic [2:0]         n;
    logic               blocked;

    assign dec_rdy = rst && ((CW'(DEPTH) - count) >= CW'(4));
    assign enq     = dec_rdy && !bus.flush;

    // The slot offset of each valid lane is the number of valid lanes below it.
    // This compacts the holes so the entries land at tail, tail+1, ...
    always_comb begin
        enq_cnt = 3'd0;
        for (int k = 0; k < 4; k++) begin
            enq_off[k] = enq_cnt[1:0];
            enq_cnt    = enq_cnt + {2'b00, bus.dec_vld[k]};
        end
    end

    // Head window. The pointer arithmetic wraps at DEPTH, so a window that crosses DEPTH-1 -> 0 has no gap.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            win_des[k]  = mem_des[head + PW'(k)];
            win_src1[k] = mem_src1[head + PW'(k)];
            win_src2[k] = mem_src2[head + PW'(k)];
            win_op[k]   = mem_op[head + PW'(k)];
            win_vld[k]  = (CW'(k) < count);
        end
    end

    // Intra-group RAW: a younger lane reads a tag that an older lane in the same window writes.
    // The checker cannot see this, because the older lane is not yet in flight.
    always_comb begin
        raw_hit = 4'b0000;
        for (int k = 1; k < 4; k++) begin
            for (int j = 0; j < k; j++) begin
                if (TW'(win_src1[k]) == TW'(win_des[j]) || TW'(win_src2[k]) == TW'(win_des[j]))
                    raw_hit[k] = 1'b1;
            end
        end
    end

    // Issue count n. Once one lane is blocked, every younger lane stays blocked, so issue is strictly in order.
    always_comb begin
        n       = 3'd0;
        blocked = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!win_vld[k] || bus.chk_hz[k] || raw_hit[k])
                blocked = 1'b1;
            if (!blocked)
                n = 3'(k + 1);
        end
        if (bus.iss_stall || bus.flush || !rst)
            n = 3'd0;
        for (int k = 0; k < 4; k++)
            fin_vld[k] = (3'(k) < n);
    end

    // Storage needs no reset. Only the entries between head and tail are ever treated as valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.dec_vld[k]) begin
                    mem_des[tail + PW'(enq_off[k])]  <= bus.dec_des[k*DES_W +: DES_W];
                    mem_src1[tail + PW'(enq_off[k])] <= bus.dec_src1[k*SRC_W +: SRC_W];
                    mem_src2[tail + PW'(enq_off[k])] <= bus.dec_src2[k*SRC_W +: SRC_W];
                    mem_op[tail + PW'(enq_off[k])]   <= bus.dec_op[k*OP_W +: OP_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            stall_cnt <= '0;
            iss_vld   <= '0;
            iss_des   <= '0;
            iss_src1  <= '0;
            iss_src2  <= '0;
            iss_op    <= '0;
        end else begin
            if (bus.flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (enq)
                    tail <= tail + PW'(enq_cnt);
                head  <= head + PW'(n);
                count <= count + (enq ? CW'(enq_cnt) : CW'(0)) - CW'(n);
            end
            // Issued lanes are already compacted, because the issued set is a prefix of the window.
            iss_vld <= fin_vld;
            for (int k = 0; k < 4; k++) begin
                iss_des[k*DES_W +: DES_W] <= fin_vld[k] ? win_des[k]  : '0;
                iss_src1[k*SRC_W +: SRC_W] <= fin_vld[k] ? win_src1[k] : '0;
                iss_src2[k*SRC_W +: SRC_W] <= fin_vld[k] ? win_src2[k] : '0;
                iss_op[k*OP_W +: OP_W]     <= fin_vld[k] ? win_op[k]   : '0;
            end
            // This counts only real hazard stalls. Empty, stalled or flushed cycles are not counted.
            if (count != '0 && n == 3'd0 && !bus.iss_stall && !bus.flush && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign bus.dec_rdy   = dec_rdy;
    assign bus.chk_vld   = win_vld;
    assign bus.fin_vld   = fin_vld;
    assign bus.iss_vld   = iss_vld;
    assign bus.iss_des   = iss_des;
    assign bus.iss_src1  = iss_src1;
    assign bus.iss_src2  = iss_src2;
    assign bus.iss_op    = iss_op;
    assign bus.count     = count;
    assign bus.stall_cnt = stall_cnt;

    for (genvar k = 0; k < 4; k++) begin : g_chk
        assign bus.chk_des[k*DES_W +: DES_W]  = win_des[k];
        assign bus.chk_src1[k*SRC_W +: SRC_W] = win_src1[k];
        assign bus.chk_src2[k*SRC_W +: SRC_W] = win_src2[k];
    end
endmodule

// File: tb/tb_raw_issue_queue.sv
module tb_raw_issue_queue;
    localparam int DEPTH = 8;

    logic clk;
    logic rst;

    raw_issue_queue_if #(.DES_W(4), .SRC_W(4), .OP_W(8), .DEPTH(DEPTH)) bus ();

    raw_issue_queue #(.DES_W(4), .SRC_W(4), .OP_W(8), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [3:0] des;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [7:0] op;
    } ent_t;

    ent_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         m_stall = 0;
    logic [3:0] obs_fin;
    int         s0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int k, input logic [3:0] d, input logic [3:0] s1,
                            input logic [3:0] s2, input logic [7:0] op);
        bus.dec_des[k*4 +: 4]  = d;
        bus.dec_src1[k*4 +: 4] = s1;
        bus.dec_src2[k*4 +: 4] = s2;
        bus.dec_op[k*8 +: 8]   = op;
    endtask

    // One clock cycle. The inputs are already driven. The task checks the combinational outputs,
    // steps the queue model, crosses the edge and then checks the registered outputs.
    task automatic do_cycle();
        int   n;
        int   sz;
        bit   blk;
        bit   rdy;
        ent_t iss[$];
        ent_t e;
        #1;
        sz  = q.size();
        n   = 0;
        blk = 0;
        for (int k = 0; k < 4; k++) begin
            if (k >= sz || bus.chk_hz[k]) blk = 1;
            else begin
                for (int j = 0; j < k; j++)
                    if (q[k].s1 == q[j].des || q[k].s2 == q[j].des) blk = 1;
            end
            if (!blk) n = k + 1;
        end
        if (bus.iss_stall || bus.flush || !rst) n = 0;
        rdy = rst && (DEPTH - sz >= 4);

        check("dec_rdy", 32'(bus.dec_rdy), 32'(rdy));
        check("chk_vld", 32'(bus.chk_vld), (sz >= 4) ? 32'hF : ((32'd1 << sz) - 1));
        for (int k = 0; k < 4 && k < sz; k++) begin
            check("chk_des",  32'(bus.chk_des[k*4 +: 4]),  32'(q[k].des));
            check("chk_src1", 32'(bus.chk_src1[k*4 +: 4]), 32'(q[k].s1));
            check("chk_src2", 32'(bus.chk_src2[k*4 +: 4]), 32'(q[k].s2));
        end
        obs_fin = bus.fin_vld;
        check("fin_vld", 32'(bus.fin_vld), (32'd1 << n) - 1);

        if (!rst) begin
            q.delete();
            m_stall = 0;
        end else if (bus.flush) begin
            q.delete();
        end else begin
            if (sz > 0 && n == 0 && !bus.iss_stall && m_stall < 65535) m_stall++;
            for (int k = 0; k < n; k++) iss.push_back(q.pop_front());
            if (rdy) begin
                for (int k = 0; k < 4; k++) begin
                    if (bus.dec_vld[k]) begin
                        e.des = bus.dec_des[k*4 +: 4];
                        e.s1  = bus.dec_src1[k*4 +: 4];
                        e.s2  = bus.dec_src2[k*4 +: 4];
                        e.op  = bus.dec_op[k*8 +: 8];
                        q.push_back(e);
                    end
                end
            end
        end

        @(posedge clk);
        #1;
        check("iss_vld", 32'(bus.iss_vld), (32'd1 << iss.size()) - 1);
        for (int k = 0; k < iss.size(); k++) begin
            check("iss_des",  32'(bus.iss_des[k*4 +: 4]),  32'(iss[k].des));
            check("iss_src1", 32'(bus.iss_src1[k*4 +: 4]), 32'(iss[k].s1));
            check("iss_src2", 32'(bus.iss_src2[k*4 +: 4]), 32'(iss[k].s2));
            check("iss_op",   32'(bus.iss_op[k*8 +: 8]),   32'(iss[k].op));
        end
        check("count",     32'(bus.count),     32'(q.size()));
        check("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
    endtask

    initial begin
        rst           = 1'b0;
        bus.flush     = 1'b0;
        bus.iss_stall = 1'b0;
        bus.chk_hz    = 4'h0;
        bus.dec_vld   = 4'hF;
        bus.dec_des   = '0;
        bus.dec_src1  = '0;
        bus.dec_src2  = '0;
        bus.dec_op    = '0;

        // reset held with all lanes valid
        repeat (2) @(posedge clk);
        #1;
        do_cycle();
        do_cycle();
        check("rst_count",   32'(bus.count),     32'd0);
        check("rst_dec_rdy", 32'(bus.dec_rdy),   32'd0);
        check("rst_iss_vld", 32'(bus.iss_vld),   32'd0);
        check("rst_stall",   32'(bus.stall_cnt), 32'd0);

        // intra-group hazard
        rst = 1'b1;
        for (int k = 0; k < 4; k++)
            set_lane(k, 4'(k + 1), 4'(8 + 2*k), 4'(9 + 2*k), 8'($urandom));
        do_cycle();
        set_lane(0, 4'd5, 4'h9, 4'hA, 8'h50);
        set_lane(1, 4'd6, 4'hB, 4'hC, 8'h61);
        set_lane(2, 4'd7, 4'h5, 4'hD, 8'h72);
        set_lane(3, 4'd8, 4'hE, 4'hF, 8'h83);
        do_cycle();
        check("intra_g1_fin", 32'(obs_fin), 32'hF);
        bus.dec_vld = 4'h0;
        do_cycle();
        check("intra_g2_fin", 32'(obs_fin), 32'h3);
        do_cycle();
        check("intra_g2b_fin", 32'(obs_fin), 32'h3);

        // external hazard that follows the blocked instruction to lane 0
        bus.dec_vld = 4'hF;
        for (int k = 0; k < 4; k++)
            set_lane(k, 4'(k + 1), 4'(8 + 2*k), 4'(9 + 2*k), 8'($urandom));
        do_cycle();
        bus.dec_vld = 4'h0;
        bus.chk_hz  = 4'b0010;
        do_cycle();
        check("ext_fin0", 32'(obs_fin), 32'h1);
        s0 = m_stall;
        bus.chk_hz = 4'b0001;
        do_cycle();
        check("ext_fin1", 32'(obs_fin), 32'h0);
        do_cycle();
        check("ext_fin2", 32'(obs_fin), 32'h0);
        bus.chk_hz = 4'b0000;
        do_cycle();
        check("ext_fin3", 32'(obs_fin), 32'h7);
        check("ext_stall_inc", 32'(bus.stall_cnt), 32'(s0 + 2));

        // full, then wrap; des < 8 and srcs >= 8 keep every window free of RAW hazards
        bus.iss_stall = 1'b1;
        bus.dec_vld   = 4'hF;
        for (int k = 0; k < 4; k++) set_lane(k, 4'(k), 4'(8 + k), 4'(12 + k), 8'(8'hA0 + k));
        do_cycle();
        for (int k = 0; k < 4; k++) set_lane(k, 4'(4 + k), 4'(8 + k), 4'(12 + k), 8'(8'hB0 + k));
        do_cycle();
        check("full_count", 32'(bus.count), 32'd8);
        for (int k = 0; k < 4; k++) set_lane(k, 4'(k), 4'hF, 4'hF, 8'hEE);
        do_cycle();
        check("full_ignore_count", 32'(bus.count),   32'd8);
        check("full_dec_rdy",      32'(bus.dec_rdy), 32'd0);
        bus.iss_stall = 1'b0;
        bus.dec_vld   = 4'h0;
        bus.chk_hz    = 4'b0100;
        do_cycle();
        check("wrap_pre_fin", 32'(obs_fin), 32'h3);
        bus.chk_hz = 4'b0000;
        do_cycle();
        check("wrap_fin",     32'(obs_fin),     32'hF);
        check("wrap_iss_des", 32'(bus.iss_des), 32'h5432);

        // sparse lanes
        bus.iss_stall = 1'b1;
        bus.dec_vld   = 4'b1010;
        set_lane(1, 4'h9, 4'h1, 4'h2, 8'h91);
        set_lane(3, 4'hA, 4'h3, 4'h4, 8'hA3);
        do_cycle();
        check("sparse_count", 32'(bus.count), 32'd4);
        check("sparse_lane2", 32'(bus.chk_des[11:8]),  32'h9);
        check("sparse_lane3", 32'(bus.chk_des[15:12]), 32'hA);

        // flush with a full enqueue and a stall
        bus.dec_vld = 4'b0011;
        do_cycle();
        check("pre_flush_count", 32'(bus.count), 32'd6);
        s0 = m_stall;
        bus.flush   = 1'b1;
        bus.dec_vld = 4'hF;
        do_cycle();
        bus.flush = 1'b0;
        check("flush_count",   32'(bus.count),     32'd0);
        check("flush_iss_vld", 32'(bus.iss_vld),   32'd0);
        check("flush_stall",   32'(bus.stall_cnt), 32'(s0));

        // random traffic, with small tags so that RAW hazards are frequent
        bus.iss_stall = 1'b0;
        for (int c = 0; c < 600; c++) begin
            bus.dec_vld = 4'($urandom);
            for (int k = 0; k < 4; k++)
                set_lane(k, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 9)),
                         4'($urandom_range(0, 9)), 8'($urandom));
            bus.chk_hz    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            bus.iss_stall = ($urandom_range(0, 7) == 0);
            bus.flush     = ($urandom_range(0, 40) == 0);
            rst           = ($urandom_range(0, 80) != 0);
            do_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
